pwm_reader_block: RTL and testbench
===================================

PWM_READER_BLOCK -- requirements
Module: pwm_reader_block

Interface
REQ-001 SHALL have parameter OUTPUT_BIT_WIDTH, default 10, width of pwm_value.
REQ-002 SHALL have port us_clk  input  1  1 MHz clock (1 us period), the single clock.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port pwm_in  input  1  asynchronous RC-receiver PWM channel.
REQ-005 SHALL have port pwm_value  output  OUTPUT_BIT_WIDTH  last accepted pulse width minus MIN_PWM_TIME_HIGH_US, clamped.
REQ-006 SHALL have port value_valid  output  1  one-cycle strobe when pwm_value updates.
REQ-007 SHALL have port pulse_error  output  1  one-cycle strobe when a pulse is rejected.
REQ-008 SHALL have port signal_lost  output  1  level; no valid pulse within SIGNAL_LOST_TIMEOUT_US.

Function
REQ-009 SHALL synchronize pwm_in through 2 flops; edges are detected on the synchronized signal, with 1 extra cycle for edge compare.
REQ-010 SHALL implement states WAIT_LOW, WAIT_RISE and MEASURE_HIGH.
REQ-011 WAIT_LOW: SHALL go to WAIT_RISE when the synchronized input is 0; this prevents measuring a partial pulse after reset or abort.
REQ-012 WAIT_RISE: on a rising edge SHALL load high_count=1 and go to MEASURE_HIGH.
REQ-013 MEASURE_HIGH: SHALL increment high_count each cycle while high; high_count is 16 bits and saturates at 0xFFFF.
REQ-014 On a falling edge in MEASURE_HIGH: width=high_count; SHALL go to WAIT_RISE.
REQ-015 Width below MIN_VALID_PULSE_US (500) or above MAX_VALID_PULSE_US (2500): SHALL assert pulse_error, leave pwm_value unchanged and assert no value_valid.
REQ-016 Accepted width: pwm_value = clamp(width, MIN_PWM_TIME_HIGH_US=1000, MAX_PWM_TIME_HIGH_US=2000) - 1000 (range 0..1000); it SHALL be registered with value_valid=1 on the cycle after falling-edge detection.
REQ-017 If high_count exceeds MAX_VALID_PULSE_US while still high: SHALL assert pulse_error once, then go to WAIT_LOW.
REQ-018 SHALL keep a 16-bit saturating timeout counter, cleared on each accepted pulse and otherwise incremented every cycle.
REQ-019 Timeout counter reaching SIGNAL_LOST_TIMEOUT_US (25000): SHALL set signal_lost=1 and force pwm_value=0 (fail-safe) with no value_valid strobe.
REQ-020 signal_lost SHALL clear in the same cycle value_valid strobes for the next accepted pulse.
REQ-021 If an accepted pulse and the timeout occur in the same cycle, the accepted pulse wins: value updates and signal_lost=0.
REQ-022 value_valid and pulse_error SHALL never be high in the same cycle.

Reset
REQ-023 On resetn=0 (asynchronous) SHALL set: state=WAIT_LOW, synchronizer flops=0, high_count=0, timeout counter=0, pwm_value=0, value_valid=0, pulse_error=0, signal_lost=1.
REQ-024 Reset asserted mid-pulse SHALL discard the pulse; after release the first measurement SHALL begin only after a low and then a rising edge.

Structure
REQ-025 common_defines.v SHALL hold MIN_PWM_TIME_HIGH_US, MAX_PWM_TIME_HIGH_US, MIN_VALID_PULSE_US, MAX_VALID_PULSE_US and SIGNAL_LOST_TIMEOUT_US; these values are shared with the PWM generator.
REQ-026 SHALL instantiate one sub-module, pwm_edge_detect: 2-flop synchronizer plus rise/fall strobes.
REQ-027 One instance SHALL serve one receiver channel; multi-channel use instantiates it N times.

Verification
REQ-028 Reset release, then a 1500 us high pulse -> value_valid once, pwm_value=500, signal_lost 1->0 on the same cycle.
REQ-029 Pulses of 900 us and 2100 us -> pwm_value=0 and pwm_value=1000 respectively, each with value_valid.
REQ-030 Pulse of 300 us -> pulse_error one cycle, pwm_value unchanged, no value_valid.
REQ-031 pwm_in held high for 3000 us -> one pulse_error at width 2501, no value until low then a fresh 1200 us pulse -> pwm_value=200.
REQ-032 Valid pulses, then pwm_in held low for 25000 us -> signal_lost=1, pwm_value=0 exactly 25000 cycles after the last accepted pulse.
REQ-033 resetn pulsed low at 700 us into a high pulse -> all outputs at reset values, and that pulse is not reported after release.

Source files
------------

// File: rtl/pwm_reader_block_pkg.sv
// pwm_reader_block_pkg: pulse timing limits shared with the PWM generator,
// plus the reader state encoding and width-to-value scaling.
package pwm_reader_block_pkg;
    localparam logic [15:0] MIN_PWM_TIME_HIGH_US   = 16'd1000;
    localparam logic [15:0] MAX_PWM_TIME_HIGH_US   = 16'd2000;
    localparam logic [15:0] MIN_VALID_PULSE_US     = 16'd500;
    localparam logic [15:0] MAX_VALID_PULSE_US     = 16'd2500;
    localparam logic [15:0] SIGNAL_LOST_TIMEOUT_US = 16'd25000;

    typedef enum logic [1:0] {WAIT_LOW, WAIT_RISE, MEASURE_HIGH} reader_state_t;

    function automatic logic [15:0] scale_width(input logic [15:0] width);
        return width < MIN_PWM_TIME_HIGH_US ? 16'd0 :
               width > MAX_PWM_TIME_HIGH_US ? MAX_PWM_TIME_HIGH_US - MIN_PWM_TIME_HIGH_US :
               width - MIN_PWM_TIME_HIGH_US;
    endfunction
endpackage

// File: rtl/pwm_edge_detect.sv
// pwm_edge_detect: 2-flop synchronizer for pwm_in with rise/fall strobes.
module pwm_edge_detect (
    input  logic us_clk,
    input  logic resetn,
    input  logic pwm_in,
    output logic pwm_sync,
    output logic sync_ready,
    output logic rise,
    output logic fall
);
    logic       pwm_meta;
    logic       pwm_prev;
    logic [1:0] fill;

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            pwm_meta <= 1'b0;
            pwm_sync <= 1'b0;
            pwm_prev <= 1'b0;
            fill     <= '0;
        end else begin
            pwm_meta <= pwm_in;
            pwm_sync <= pwm_meta;
            pwm_prev <= pwm_sync;
            fill     <= {fill[0], 1'b1};
        end
    end

    // pwm_sync only reflects the pin once both synchronizer stages have refilled
    assign sync_ready = fill[1];
    assign rise       = pwm_sync & ~pwm_prev;
    assign fall       = ~pwm_sync & pwm_prev;
endmodule

// File: rtl/pwm_reader_block.sv
// pwm_reader_block: measures RC-receiver pulse width in us, validates it and
// reports a scaled value, with pulse-error strobes and a signal-lost fail-safe.
module pwm_reader_block
    import pwm_reader_block_pkg::*;
#(
    parameter int OUTPUT_BIT_WIDTH = 10
) (
    input  logic                        us_clk,
    input  logic                        resetn,
    input  logic                        pwm_in,
    output logic [OUTPUT_BIT_WIDTH-1:0] pwm_value,
    output logic                        value_valid,
    output logic                        pulse_error,
    output logic                        signal_lost
);
    reader_state_t state, state_nxt;
    logic [15:0]   high_count, high_count_nxt, timeout_count;
    logic          pwm_sync, sync_ready, rise, fall;
    logic          accept, reject, lost_hit;

    pwm_edge_detect u_edge (
        .us_clk     (us_clk),
        .resetn     (resetn),
        .pwm_in     (pwm_in),
        .pwm_sync   (pwm_sync),
        .sync_ready (sync_ready),
        .rise       (rise),
        .fall       (fall)
    );

    always_comb begin
        state_nxt      = state;
        high_count_nxt = high_count;
        accept         = 1'b0;
        reject         = 1'b0;
        case (state)
            WAIT_LOW:  state_nxt = (sync_ready && !pwm_sync) ? WAIT_RISE : WAIT_LOW;
            WAIT_RISE: begin
                state_nxt      = rise ? MEASURE_HIGH : WAIT_RISE;
                high_count_nxt = rise ? 16'd1 : high_count;
            end
            MEASURE_HIGH: begin
                if (fall) begin
                    state_nxt = WAIT_RISE;
                    accept    = high_count >= MIN_VALID_PULSE_US && high_count <= MAX_VALID_PULSE_US;
                    reject    = !accept;
                end else if (high_count >= MAX_VALID_PULSE_US) begin
                    state_nxt = WAIT_LOW;
                    reject    = 1'b1;
                end else begin
                    high_count_nxt = (&high_count) ? high_count : high_count + 16'd1;
                end
            end
            default: state_nxt = WAIT_LOW;
        endcase
    end

    // fires on the cycle the timeout counter reaches the limit; an accepted pulse overrides it
    assign lost_hit = !accept && timeout_count + 16'd1 == SIGNAL_LOST_TIMEOUT_US;

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            state         <= WAIT_LOW;
            high_count    <= '0;
            timeout_count <= '0;
            pwm_value     <= '0;
            value_valid   <= 1'b0;
            pulse_error   <= 1'b0;
            signal_lost   <= 1'b1;
        end else begin
            state         <= state_nxt;
            high_count    <= high_count_nxt;
            timeout_count <= accept ? '0 : (&timeout_count) ? timeout_count : timeout_count + 16'd1;
            pwm_value     <= accept ? OUTPUT_BIT_WIDTH'(scale_width(high_count)) : lost_hit ? '0 : pwm_value;
            value_valid   <= accept;
            pulse_error   <= reject;
            signal_lost   <= accept ? 1'b0 : lost_hit ? 1'b1 : signal_lost;
        end
    end
endmodule

// File: tb/tb_pwm_reader_block.sv
// tb_pwm_reader_block: directed pulse table, corner sequences and random pulses
// checked every cycle against an event-schedule reference model.
module tb_pwm_reader_block;
    logic       us_clk = 1'b0;
    logic       resetn = 1'b0;
    logic       pwm_in = 1'b0;
    logic [9:0] pwm_value;
    logic       value_valid, pulse_error, signal_lost;

    pwm_reader_block #(.OUTPUT_BIT_WIDTH(10)) dut (
        .us_clk      (us_clk),
        .resetn      (resetn),
        .pwm_in      (pwm_in),
        .pwm_value   (pwm_value),
        .value_valid (value_valid),
        .pulse_error (pulse_error),
        .signal_lost (signal_lost)
    );

    always #5 us_clk = ~us_clk;

    typedef struct {int at; bit err; int val;} ev_t;
    typedef struct {int width; bit vv; bit pe; int val;} vec_t;

    ev_t  evq[$];
    ev_t  ev;
    vec_t vecs[12];
    int   cyc = 0, last_acc = 0, checks = 0, errors = 0, m_val = 0;
    bit   m_vv = 0, m_pe = 0, m_lost = 1, acc;

    function automatic int ref_value(input int w);
        return w < 1000 ? 0 : w > 2000 ? 1000 : w - 1000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 50) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: outcomes are scheduled by the stimulus from pulse widths;
    // each edge applies due outcomes and the 25000-cycle timeout since the last accept.
    always @(posedge us_clk) begin
        cyc++;
        m_vv = 0;
        m_pe = 0;
        if (!resetn) begin
            m_val = 0;
            m_lost = 1;
            last_acc = cyc;
            evq.delete();
        end else begin
            acc = 0;
            if (evq.size() > 0 && evq[0].at == cyc) begin
                ev = evq.pop_front();
                if (ev.err) m_pe = 1;
                else begin
                    m_vv = 1;
                    m_val = ev.val;
                    m_lost = 0;
                    last_acc = cyc;
                    acc = 1;
                end
            end
            if (!acc && cyc == last_acc + 25000) begin
                m_lost = 1;
                m_val = 0;
            end
        end
    end

    always @(negedge us_clk) begin
        if (!resetn) begin
            check("reset_state", 32'({value_valid, pulse_error, signal_lost, pwm_value}), 32'({1'b0, 1'b0, 1'b1, 10'd0}));
        end else begin
            check("value_valid", 32'(value_valid), 32'(m_vv));
            check("pulse_error", 32'(pulse_error), 32'(m_pe));
            check("signal_lost", 32'(signal_lost), 32'(m_lost));
            check("pwm_value", 32'(pwm_value), m_val);
            check("valid_error_exclusive", 32'(value_valid & pulse_error), 0);
        end
    end

    task automatic wait_until(input int at);
        do @(negedge us_clk); while (cyc < at);
    endtask

    // high for w sampled cycles; returns the edge at which the outcome is registered
    task automatic pulse(input int w, output int at);
        int e0;
        @(posedge us_clk);
        #1 pwm_in = 1'b1;
        e0 = cyc;
        if (w > 2500) evq.push_back('{e0 + 2503, 1'b1, 0});
        repeat (w) @(posedge us_clk);
        #1 pwm_in = 1'b0;
        if (w <= 2500) evq.push_back('{cyc + 3, w < 500, ref_value(w)});
        at = w > 2500 ? e0 + 2503 : cyc + 3;
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int e0, at, a;
        vecs = '{'{1500, 1'b1, 1'b0, 500}, '{900, 1'b1, 1'b0, 0}, '{2100, 1'b1, 1'b0, 1000},
                 '{300, 1'b0, 1'b1, 1000}, '{500, 1'b1, 1'b0, 0}, '{499, 1'b0, 1'b1, 0},
                 '{2500, 1'b1, 1'b0, 1000}, '{2501, 1'b0, 1'b1, 1000}, '{1001, 1'b1, 1'b0, 1},
                 '{1999, 1'b1, 1'b0, 999}, '{1000, 1'b1, 1'b0, 0}, '{2000, 1'b1, 1'b0, 1000}};
        repeat (3) @(posedge us_clk);
        #1 resetn = 1'b1;
        wait_until(cyc + 2);
        check("start_signal_lost", 32'(signal_lost), 1);
        check("start_pwm_value", 32'(pwm_value), 0);
        foreach (vecs[i]) begin
            pulse(vecs[i].width, at);
            wait_until(at);
            check($sformatf("vec%0d_valid", i), 32'(value_valid), 32'(vecs[i].vv));
            check($sformatf("vec%0d_error", i), 32'(pulse_error), 32'(vecs[i].pe));
            check($sformatf("vec%0d_value", i), 32'(pwm_value), vecs[i].val);
            check($sformatf("vec%0d_lost", i), 32'(signal_lost), 0);
            repeat (10) @(posedge us_clk);
        end
        // input stuck high: one error once the count passes 2500, nothing at the late fall
        @(posedge us_clk);
        #1 pwm_in = 1'b1;
        e0 = cyc;
        evq.push_back('{e0 + 2503, 1'b1, 0});
        wait_until(e0 + 2503);
        check("stuck_error", 32'(pulse_error), 1);
        wait_until(e0 + 2504);
        check("stuck_error_once", 32'(pulse_error), 0);
        wait_until(e0 + 2999);
        @(posedge us_clk);
        #1 pwm_in = 1'b0;
        at = cyc + 3;
        wait_until(at);
        check("stuck_no_valid", 32'(value_valid), 0);
        check("stuck_value_held", 32'(pwm_value), 1000);
        repeat (20) @(posedge us_clk);
        pulse(1200, at);
        wait_until(at);
        check("fresh_valid", 32'(value_valid), 1);
        check("fresh_value", 32'(pwm_value), 200);
        // signal loss exactly 25000 cycles after the last accepted pulse
        a = at;
        wait_until(a + 24999);
        check("pre_timeout_lost", 32'(signal_lost), 0);
        check("pre_timeout_value", 32'(pwm_value), 200);
        wait_until(a + 25000);
        check("timeout_lost", 32'(signal_lost), 1);
        check("timeout_value", 32'(pwm_value), 0);
        check("timeout_no_valid", 32'(value_valid), 0);
        repeat (5) @(posedge us_clk);
        pulse(1700, at);
        wait_until(at);
        check("recover_valid", 32'(value_valid), 1);
        check("recover_lost", 32'(signal_lost), 0);
        check("recover_value", 32'(pwm_value), 700);
        // reset 700 us into a pulse: that pulse must never be reported
        repeat (10) @(posedge us_clk);
        @(posedge us_clk);
        #1 pwm_in = 1'b1;
        repeat (700) @(posedge us_clk);
        #1 resetn = 1'b0;
        e0 = cyc;
        wait_until(e0 + 1);
        check("abort_reset_value", 32'(pwm_value), 0);
        check("abort_reset_lost", 32'(signal_lost), 1);
        repeat (3) @(posedge us_clk);
        #1 resetn = 1'b1;
        repeat (800) @(posedge us_clk);
        #1 pwm_in = 1'b0;
        at = cyc + 3;
        wait_until(at);
        check("abort_no_valid", 32'(value_valid), 0);
        check("abort_no_error", 32'(pulse_error), 0);
        check("abort_value", 32'(pwm_value), 0);
        check("abort_lost", 32'(signal_lost), 1);
        repeat (10) @(posedge us_clk);
        pulse(1300, at);
        wait_until(at);
        check("post_abort_valid", 32'(value_valid), 1);
        check("post_abort_value", 32'(pwm_value), 300);
        check("post_abort_lost", 32'(signal_lost), 0);
        // random widths across reject, clamp and overlong regions
        repeat (10) begin
            pulse($urandom_range(200, 2700), at);
            repeat ($urandom_range(3, 60)) @(posedge us_clk);
        end
        repeat (20) @(posedge us_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
